// File: rtl/fir_output_collector.sv
// Output collector for the folded FIR: tracks fold phase, drops pipeline-fill
// results, and buffers accepted samples in a show-ahead valid/ready FIFO.
`timescale 1ns/1ps
module fir_output_collector #(
  parameter int WIDTH      = 16,
  parameter int FOLD       = 29,
  parameter int PHASE      = 2,
  parameter int SKIP       = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              fir_dout,
  output logic [WIDTH-1:0]              m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overflow,
  output logic [20:0]                   sample_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int CW = 21;
  localparam logic [PW-1:0] PHASE_LAST = PW'(FOLD - 1);
  localparam logic [PW-1:0] PHASE_HIT  = PW'(PHASE);
  localparam logic [SW-1:0] SKIP_LAST  = SW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_RUN
  } state_e;

  state_e            state_q, state_d, eff_state;
  logic [PW-1:0]     phase_q, phase_d;
  logic [SW-1:0]     skip_cnt_q, skip_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic              overflow_q, overflow_d;
  logic [CW-1:0]     sample_cnt_q, sample_cnt_d;
  logic              strobe, push_req, do_push, do_pop, full, empty;

  // Fold phase: advances on enabled cycles only, wraps at FOLD-1.
  always_comb begin
    phase_d = phase_q;
    if (en) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  assign strobe = en && (phase_q == PHASE_HIT);

  // FSM state register plus skip counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Next-state logic; IDLE leaves on the same edge as a possible strobe, so
  // the strobe is judged against the state being entered (eff_state).
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_IDLE && en) begin
      eff_state = (SKIP > 0) ? ST_SKIP : ST_RUN;
    end
    state_d    = eff_state;
    skip_cnt_d = skip_cnt_q;
    if (eff_state == ST_SKIP && strobe) begin
      skip_cnt_d = skip_cnt_q + 1'b1;
      if (skip_cnt_q == SKIP_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  // FSM output: a strobe in RUN requests a FIFO push.
  always_comb begin
    push_req = strobe && (eff_state == ST_RUN);
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == LEVEL_FULL);
  assign do_pop  = !empty && m_ready;
  assign do_push = push_req && (!full || do_pop);

  // FIFO pointers, occupancy, overflow flag and saturating accept counter.
  always_comb begin
    wr_ptr_d     = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d   = overflow_q | (push_req && full && !do_pop);
    sample_cnt_d = sample_cnt_q;
    if (do_push && sample_cnt_q != '1) begin
      sample_cnt_d = sample_cnt_q + 1'b1;
    end
  end

  // FIFO storage write.
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = fir_dout;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      phase_q      <= phase_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign m_valid    = !empty;
  assign m_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow   = overflow_q;
  assign sample_cnt = sample_cnt_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_fir_output_collector.sv
// Bench for fir_output_collector: reference model with an expected-sample queue.
`timescale 1ns/1ps
module tb_fir_output_collector;

  localparam int WIDTH = 16;
  localparam int FOLD  = 29;
  localparam int PHASE = 2;
  localparam int SKIP  = 1;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst, en, m_ready;
  logic [WIDTH-1:0]  fir_dout, m_data;
  logic              m_valid, overflow;
  logic [20:0]       sample_cnt;
  logic [3:0]        fifo_level;
  logic [42:0]       dut_vec;

  int checks = 0;
  int errors = 0;

  // reference model state
  int               mphase, mstate, mskip, mcnt, idx;
  logic             movf;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  fir_output_collector #(
    .WIDTH(WIDTH), .FOLD(FOLD), .PHASE(PHASE), .SKIP(SKIP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fir_dout(fir_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .sample_cnt(sample_cnt), .fifo_level(fifo_level)
  );

  assign dut_vec = {m_valid, m_data, fifo_level, overflow, sample_cnt};

  function automatic logic [42:0] exp_vec();
    logic [WIDTH-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    return {exp_q.size() != 0, h, 4'(exp_q.size()), movf, 21'(mcnt)};
  endfunction

  function automatic bit is_run_strobe(input int k);
    return (k >= 31) && ((k - 2) % 29 == 0);
  endfunction

  // drive one cycle, advance the model at the edge, return #1 after it
  task automatic tick(input logic r, input logic e, input logic [WIDTH-1:0] d, input logic rdy);
    bit full, pop;
    int eff;
    rst = r; en = e; fir_dout = d; m_ready = rdy;
    @(posedge clk);
    if (!r) begin
      mphase = 0; mstate = 0; mskip = 0; mcnt = 0; idx = 0; movf = 1'b0;
      exp_q.delete();
    end else begin
      full = (exp_q.size() == DEPTH);
      pop  = rdy && (exp_q.size() != 0);
      if (pop) void'(exp_q.pop_front());
      if (e) begin
        eff = (mstate == 0) ? ((SKIP > 0) ? 1 : 2) : mstate;
        if (mphase == PHASE) begin
          if (eff == 1) begin
            mskip++;
            if (mskip == SKIP) eff = 2;
          end else if (!full || pop) begin
            exp_q.push_back(d);
            mcnt++;
          end else begin
            movf = 1'b1;
          end
        end
        mstate = eff;
        mphase = (mphase == FOLD - 1) ? 0 : mphase + 1;
        idx++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'($urandom), 16'($urandom), 1'($urandom));
      checks++;
      if (dut_vec !== 43'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, dut_vec);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 96; k++) begin
      tick(1'b1, 1'b1, 16'(k), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL stream_sb k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 2) begin
        checks++;
        if ({m_valid, fifo_level} !== 5'd0) begin
          errors++;
          $display("FAIL stream_skip got v=%b l=%0d exp v=0 l=0", m_valid, fifo_level);
        end
      end
      if (k == 31 || k == 60 || k == 89) begin
        checks++;
        if ({m_valid, m_data} !== {1'b1, 16'(k)}) begin
          errors++;
          $display("FAIL stream_capture k=%0d got v=%b d=%0d exp v=1 d=%0d", k, m_valid, m_data, k);
        end
      end
      if (k == 89) begin
        checks++;
        if (sample_cnt !== 21'd3) begin
          errors++;
          $display("FAIL stream_count got=%0d exp=3", sample_cnt);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] pushed[$];
    logic [WIDTH-1:0] d;
    do_reset();
    for (int k = 0; k < 264; k++) begin
      d = 16'($urandom);
      if (is_run_strobe(k)) pushed.push_back(d);
      tick(1'b1, 1'b1, d, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_sb k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 234) begin
        checks++;
        if ({fifo_level, overflow} !== {4'd8, 1'b0}) begin
          errors++;
          $display("FAIL ovf_full_noflag got l=%0d o=%b exp l=8 o=0", fifo_level, overflow);
        end
      end
    end
    checks++;
    if ({fifo_level, overflow, sample_cnt} !== {4'd8, 1'b1, 21'd8}) begin
      errors++;
      $display("FAIL ovf_state got l=%0d o=%b c=%0d exp l=8 o=1 c=8", fifo_level, overflow, sample_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({m_valid, m_data} !== {1'b1, pushed[i]}) begin
        errors++;
        $display("FAIL ovf_drain i=%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, pushed[i]);
      end
      tick(1'b1, 1'b0, '0, 1'b1);
      checks++;
      if (overflow !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky i=%0d got=%b exp=1", i, overflow);
      end
    end
    checks++;
    if ({m_valid, fifo_level} !== 5'd0) begin
      errors++;
      $display("FAIL ovf_empty got v=%b l=%0d exp v=0 l=0", m_valid, fifo_level);
    end
  endtask

  task automatic test_full_pushpop();
    logic [WIDTH-1:0] pushed[$];
    logic [WIDTH-1:0] d;
    do_reset();
    for (int k = 0; k < 264; k++) begin
      d = 16'($urandom);
      if (is_run_strobe(k)) pushed.push_back(d);
      tick(1'b1, 1'b1, d, (k == 263) ? 1'b1 : 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pp_sb k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({fifo_level, overflow, sample_cnt} !== {4'd8, 1'b0, 21'd9}) begin
      errors++;
      $display("FAIL pp_state got l=%0d o=%b c=%0d exp l=8 o=0 c=9", fifo_level, overflow, sample_cnt);
    end
    for (int i = 1; i < 9; i++) begin
      checks++;
      if ({m_valid, m_data} !== {1'b1, pushed[i]}) begin
        errors++;
        $display("FAIL pp_order i=%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, pushed[i]);
      end
      tick(1'b1, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_pause();
    int n = 0, paused = 0, rises = 0;
    int t_rise[2];
    logic [WIDTH-1:0] d_rise[2];
    logic prev_v = 1'b0, e;
    do_reset();
    for (int t = 0; t < 200 && rises < 2; t++) begin
      e = !(n == 41 && paused < 10);
      if (!e) paused++;
      tick(1'b1, e, e ? 16'(n) : 16'($urandom), 1'b1);
      if (e) n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pause_sb t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
      end
      if (m_valid && !prev_v) begin
        t_rise[rises] = t;
        d_rise[rises] = m_data;
        rises++;
      end
      prev_v = m_valid;
    end
    checks++;
    if (rises != 2) begin
      errors++;
      $display("FAIL pause_timeout got %0d captures exp 2", rises);
    end else begin
      checks++;
      if (t_rise[1] - t_rise[0] != 39) begin
        errors++;
        $display("FAIL pause_delay got=%0d exp=39", t_rise[1] - t_rise[0]);
      end
      if ({d_rise[0], d_rise[1]} !== {16'd31, 16'd60}) begin
        errors++;
        $display("FAIL pause_data got %0d,%0d exp 31,60", d_rise[0], d_rise[1]);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int k = 0; k < 90; k++) tick(1'b1, 1'b1, 16'(k), 1'b0);
    checks++;
    if ({fifo_level, m_data} !== {4'd3, 16'd31}) begin
      errors++;
      $display("FAIL mrst_fill got l=%0d d=%0d exp l=3 d=31", fifo_level, m_data);
    end
    tick(1'b0, 1'b1, 16'($urandom), 1'b1);
    checks++;
    if (dut_vec !== 43'd0) begin
      errors++;
      $display("FAIL mrst_clear got=%h exp=0", dut_vec);
    end
    for (int k = 0; k < 32; k++) begin
      tick(1'b1, 1'b1, 16'(k), 1'b0);
      if (k == 2) begin
        checks++;
        if ({m_valid, fifo_level} !== 5'd0) begin
          errors++;
          $display("FAIL mrst_reskip got v=%b l=%0d exp v=0 l=0", m_valid, fifo_level);
        end
      end
    end
    checks++;
    if ({m_valid, m_data, fifo_level} !== {1'b1, 16'd31, 4'd1}) begin
      errors++;
      $display("FAIL mrst_first got v=%b d=%0d l=%0d exp v=1 d=31 l=1", m_valid, m_data, fifo_level);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; fir_dout = '0; m_ready = 1'b0;
    test_reset();
    test_stream();
    test_overflow();
    test_full_pushpop();
    test_pause();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
